exc_ctrl: RTL
=============

Name: exc_ctrl

Overview:
Exception/interrupt controller (CP0 core) for the 5-stage MIPS pipeline, sitting at the M stage. It collects the exception code that travels down from fetch/decode, including fetch AdEL and the branch-delay flag, and merges it with the external interrupt lines. It decides whether to trap, latches EPC/Cause/SR, and drives the flush and redirect signals that sequence the pipeline into the handler and back out on eret. It also serves mfc0/mtc0 accesses to SR (12), Cause (13), EPC (14) and PRId (15).

Parameters:
HANDLER_ADDR, 32'h0000_4180, redirect target on trap
PRID, 32'h2021_0601, read-only PRId value

Ports:
clk  in  1  system clock, all state updates on rising edge
reset  in  1  asynchronous, active-high; clears all state immediately
exc_m  in  5  exception code of the M-stage instruction; 0 = none (AdEL = 4)
bd_m  in  1  M-stage instruction is in a branch delay slot
pc_m  in  32  PC of the M-stage instruction
eret_m  in  1  M-stage instruction is eret
hwint  in  6  external interrupt lines, level-sensitive
cp0_we  in  1  mtc0 write enable (M stage)
cp0_addr  in  5  CP0 register number for read/write
cp0_wdata  in  32  mtc0 data
cp0_rdata  out  32  mfc0 data, combinational from cp0_addr
exc_req  out  1  trap taken this cycle; flush F/D/E/M, kill M-stage write-back
eret_req  out  1  eret taken this cycle; flush F/D/E
redirect_pc  out  32  next fetch PC when exc_req or eret_req is high, else 0
exl  out  1  SR.EXL, in handler

Behaviour:
- Reset: SR=0, Cause=0, EPC=0, FSM=RUN. Outputs exc_req=0, eret_req=0, redirect_pc=0, exl=0.
- FSM states are RUN (EXL=0) and HANDLER (EXL=1). The FSM is the sole source of exl.
- SR layout: IM=[15:10], EXL=[1], IE=[0]; all other bits read 0.
- Cause layout: BD=[31], IP=[15:10], ExcCode=[6:2]; all other bits read 0.
- Cause.IP <= hwint every cycle, regardless of state.
- int_pend = IE & |(hwint & IM), using current registered SR. It is valid in RUN only.
- RUN behaviour:
  - take = int_pend | (exc_m != 0). exc_req = take, combinational, same cycle.
  - Priority: interrupt over instruction exception. ExcCode <= 0 for an interrupt, else exc_m.
  - On take at the clock edge: EPC <= bd_m ? pc_m-4 : pc_m, using raw PC (misaligned AdEL PC kept as-is). Cause.BD <= bd_m. SR.EXL <= 1. FSM -> HANDLER.
  - redirect_pc = HANDLER_ADDR while exc_req is high.
  - take and cp0_we in the same cycle: take wins and the write is dropped.
  - eret_m in RUN is ignored: no redirect, no state change.
- HANDLER behaviour:
  - Interrupts and exc_m are ignored; exc_req stays 0.
  - eret_m=1: eret_req=1 (combinational), redirect_pc = EPC. At the edge, SR.EXL <= 0 and FSM -> RUN.
  - A trap can be taken at the earliest in the cycle after return.
- mtc0 (cp0_we=1, not dropped), applied at the edge:
  - addr 12: writes IM, EXL, IE only. Writing EXL also moves the FSM to match (EXL=0 -> RUN, EXL=1 -> HANDLER).
  - addr 14: EPC <= cp0_wdata (full 32 bits).
  - addr 13, 15 and any other address: write ignored.
- mfc0: cp0_rdata returns SR/Cause/EPC/PRID for addr 12/13/14/15 and 0 otherwise. Reads show the registered (pre-edge) value; there is no write-through forwarding.
- Asynchronous reset asserted mid-handler forces RUN and EXL=0 immediately, and outputs drop without waiting for a clock edge.
- redirect_pc arithmetic: pc_m-4 is 32-bit modulo. pc_m=0 with bd_m=1 gives EPC=32'hFFFF_FFFC.

Test Plan:
- Fetch AdEL: RUN, exc_m=4, pc_m=32'h0000_5000, bd_m=0 -> same cycle exc_req=1, redirect_pc=32'h4180. Next cycle EPC=32'h5000, Cause=32'h0000_0010, exl=1.
- Delay slot: exc_m=4, bd_m=1, pc_m=32'h0000_3006 -> EPC=32'h3002, Cause[31]=1, ExcCode=4.
- Interrupt priority: mtc0 SR=32'h0000_0401, then hwint=6'b000001 and exc_m=10 in the same cycle -> exc_req=1, ExcCode=0, Cause.IP=6'b000001 (Cause=32'h0000_0400).
- Masking: SR.IE=0 or EXL=1 with hwint=6'h3F -> exc_req stays 0. Cause[15:10] still tracks 6'h3F.
- eret: in HANDLER with EPC=32'h3010, eret_m=1 -> eret_req=1, redirect_pc=32'h3010. Next cycle exl=0. A second eret in RUN produces no eret_req.
- Collisions and reset: mtc0 EPC=32'h1234 in the same cycle as exc_m=12 -> EPC=pc_m, write dropped. Async reset pulse in HANDLER -> exl=0 immediately, and all CP0 reads return 0 except PRId=32'h2021_0601.

Source files
------------

// File: rtl/exc_ctrl.sv
// CP0 exception/interrupt controller at the M stage.
// Decides on traps and eret, holds SR/Cause/EPC, and drives pipeline flush/redirect.
module exc_ctrl #(
  parameter logic [31:0] HANDLER_ADDR = 32'h0000_4180,
  parameter logic [31:0] PRID         = 32'h2021_0601
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  exc_m,
  input  logic        bd_m,
  input  logic [31:0] pc_m,
  input  logic        eret_m,
  input  logic [5:0]  hwint,
  input  logic        cp0_we,
  input  logic [4:0]  cp0_addr,
  input  logic [31:0] cp0_wdata,
  output logic [31:0] cp0_rdata,
  output logic        exc_req,
  output logic        eret_req,
  output logic [31:0] redirect_pc,
  output logic        exl
);

  typedef enum logic {
    RUN     = 1'b0,
    HANDLER = 1'b1
  } state_t;

  localparam logic [4:0] A_SR    = 5'd12;
  localparam logic [4:0] A_CAUSE = 5'd13;
  localparam logic [4:0] A_EPC   = 5'd14;
  localparam logic [4:0] A_PRID  = 5'd15;

  state_t      state;
  logic [5:0]  sr_im;
  logic        sr_ie;
  logic [31:0] epc;
  logic        cause_bd;
  logic [5:0]  cause_ip;
  logic [4:0]  cause_code;

  logic        in_run;
  logic        int_pend;
  logic        take;
  logic        eret_go;
  logic [31:0] sr_val;
  logic [31:0] cause_val;

  // SR.EXL is not stored separately; it is the FSM state itself.
  assign exl = (state == HANDLER);

  always_comb begin
    in_run    = (state == RUN);
    int_pend  = sr_ie & (|(hwint & sr_im));
    take      = in_run & (int_pend | (|exc_m)) & ~reset;
    eret_go   = ~in_run & eret_m & ~reset;
    sr_val    = {16'b0, sr_im, 8'b0, exl, sr_ie};
    cause_val = {cause_bd, 15'b0, cause_ip, 3'b0,
                 cause_code, 2'b0};
  end

  always_comb begin
    exc_req     = take;
    eret_req    = eret_go;
    redirect_pc = 32'b0;
    if (take) begin
      redirect_pc = HANDLER_ADDR;
    end else if (eret_go) begin
      redirect_pc = epc;
    end
  end

  always_comb begin
    case (cp0_addr)
      A_SR:    cp0_rdata = sr_val;
      A_CAUSE: cp0_rdata = cause_val;
      A_EPC:   cp0_rdata = epc;
      A_PRID:  cp0_rdata = PRID;
      default: cp0_rdata = 32'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= RUN;
      sr_im      <= 6'b0;
      sr_ie      <= 1'b0;
      epc        <= 32'b0;
      cause_bd   <= 1'b0;
      cause_ip   <= 6'b0;
      cause_code <= 5'b0;
    end else begin
      cause_ip <= hwint;
      if (take) begin
        // A trap drops any mtc0 issued alongside it.
        epc        <= bd_m ? (pc_m - 32'd4) : pc_m;
        cause_bd   <= bd_m;
        cause_code <= int_pend ? 5'd0 : exc_m;
        state      <= HANDLER;
      end else begin
        if (eret_go) begin
          state <= RUN;
        end
        if (cp0_we) begin
          case (cp0_addr)
            A_SR: begin
              sr_im <= cp0_wdata[15:10];
              sr_ie <= cp0_wdata[0];
              state <= cp0_wdata[1] ? HANDLER : RUN;
            end
            A_EPC: epc <= cp0_wdata;
            default: ;
          endcase
        end
      end
    end
  end

endmodule
